// File: rtl/prototype_builder.sv
// Builds per-class prototype vectors (rounded mean of 2**LOG2_SAMPLES training vectors per class)
// from a labelled 4-bit element stream and writes them to the h/d prototype BRAM write ports.
module prototype_builder #(
   parameter int VECTOR_SIZE  = 1024,
   parameter int LOG2_SAMPLES = 4,
   parameter int ADDR_BITS    = $clog2(VECTOR_SIZE),
   parameter int ACC_BITS     = 4 + LOG2_SAMPLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [3:0]           s_data,
   input  logic                 s_label,
   input  logic                 s_last,
   output logic                 wr_en_h,
   output logic                 wr_en_d,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [3:0]           wr_data_h,
   output logic [3:0]           wr_data_d,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int CW = LOG2_SAMPLES + 1;
   localparam logic [CW-1:0] FULL = CW'(2**LOG2_SAMPLES);
   localparam logic [ACC_BITS-1:0] HALF = ACC_BITS'(2**(LOG2_SAMPLES-1));

   typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, WRITE, FINISHED} state_t;

   state_t               state, state_next;
   logic [ADDR_BITS-1:0] idx;
   logic [CW-1:0]        cnt_h, cnt_d, cnt_h_nxt, cnt_d_nxt;
   logic                 cur_label, cur_drop;
   logic                 accept, idx_last, eff_label, eff_drop;
   logic [ACC_BITS-1:0]  acc_h [VECTOR_SIZE];
   logic [ACC_BITS-1:0]  acc_d [VECTOR_SIZE];
   logic [ACC_BITS-1:0]  rnd_h, rnd_d;

   assign s_ready = (state == COLLECT);
   assign busy    = (state == CLEAR) || (state == COLLECT) || (state == WRITE);
   assign done    = (state == FINISHED);

   // Label and drop decision come straight from the stream on element 0, from the latch afterwards
   always_comb begin
      accept    = (state == COLLECT) && s_valid;
      idx_last  = (idx == ADDR_BITS'(VECTOR_SIZE - 1));
      eff_label = (idx == '0) ? s_label : cur_label;
      eff_drop  = (idx == '0) ? (s_label ? (cnt_d == FULL) : (cnt_h == FULL)) : cur_drop;
      cnt_h_nxt = cnt_h;
      cnt_d_nxt = cnt_d;
      if (accept && idx_last && !eff_drop) begin
         if (eff_label) cnt_d_nxt = cnt_d + CW'(1);
         else           cnt_h_nxt = cnt_h + CW'(1);
      end
      rnd_h = acc_h[idx] + HALF;
      rnd_d = acc_d[idx] + HALF;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start) state_next = CLEAR;
         CLEAR:    if (idx_last) state_next = COLLECT;
         COLLECT:  if (cnt_h_nxt == FULL && cnt_d_nxt == FULL) state_next = WRITE;
         WRITE:    if (idx_last) state_next = FINISHED;
         FINISHED: if (!start) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         cnt_h     <= '0;
         cnt_d     <= '0;
         cur_label <= 1'b0;
         cur_drop  <= 1'b0;
         err       <= 1'b0;
         wr_en_h   <= 1'b0;
         wr_en_d   <= 1'b0;
         wr_addr   <= '0;
         wr_data_h <= '0;
         wr_data_d <= '0;
      end else begin
         wr_en_h <= 1'b0;
         wr_en_d <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  err   <= 1'b0;
                  cnt_h <= '0;
                  cnt_d <= '0;
                  idx   <= '0;
               end
            end
            CLEAR: idx <= idx_last ? '0 : idx + ADDR_BITS'(1);
            COLLECT: begin
               if (accept) begin
                  idx   <= idx_last ? '0 : idx + ADDR_BITS'(1);
                  cnt_h <= cnt_h_nxt;
                  cnt_d <= cnt_d_nxt;
                  if (idx == '0) begin
                     cur_label <= s_label;
                     cur_drop  <= eff_drop;
                  end
                  if (eff_drop || (s_last != idx_last)) err <= 1'b1;
               end
            end
            WRITE: begin
               wr_en_h   <= 1'b1;
               wr_en_d   <= 1'b1;
               wr_addr   <= idx;
               wr_data_h <= rnd_h[ACC_BITS-1 -: 4];
               wr_data_d <= rnd_d[ACC_BITS-1 -: 4];
               idx       <= idx_last ? '0 : idx + ADDR_BITS'(1);
            end
            default: ;
         endcase
      end
   end

   // Accumulator arrays carry no reset; CLEAR initialises them every session
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            acc_h[idx] <= '0;
            acc_d[idx] <= '0;
         end else if (accept && !eff_drop) begin
            if (eff_label) acc_d[idx] <= acc_d[idx] + ACC_BITS'(s_data);
            else           acc_h[idx] <= acc_h[idx] + ACC_BITS'(s_data);
         end
      end
   end

endmodule

// File: tb/tb_prototype_builder.sv
// Randomised scoreboard bench for prototype_builder (VECTOR_SIZE=16, LOG2_SAMPLES=2).
module tb_prototype_builder;

   localparam int VS = 16;
   localparam int L  = 2;
   localparam int NS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [3:0] s_data = '0;
   logic       s_label = 1'b0;
   logic       s_last = 1'b0;
   logic       wr_en_h, wr_en_d;
   logic [3:0] wr_addr;
   logic [3:0] wr_data_h, wr_data_d;
   logic       busy, done, err;

   always #5 clk = ~clk;

   prototype_builder #(.VECTOR_SIZE(VS), .LOG2_SAMPLES(L)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_label(s_label), .s_last(s_last),
      .wr_en_h(wr_en_h), .wr_en_d(wr_en_d), .wr_addr(wr_addr),
      .wr_data_h(wr_data_h), .wr_data_d(wr_data_d),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {int addr; int h; int d;} wr_t;
   wr_t exp_q[$];
   wr_t mon_e;

   int errors = 0;
   int checks = 0;
   int sum_h[VS];
   int sum_d[VS];
   int cnt_h, cnt_d;
   bit exp_err;
   int vbuf[VS];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every write strobe must match the next expected prototype entry
   always @(negedge clk) begin
      if (wr_en_h || wr_en_d) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d h=%0d d=%0d, expected no write", wr_addr, wr_data_h, wr_data_d);
         end else begin
            mon_e = exp_q.pop_front();
            if (wr_en_h !== 1'b1 || wr_en_d !== 1'b1 || wr_addr !== 4'(mon_e.addr) ||
                wr_data_h !== 4'(mon_e.h) || wr_data_d !== 4'(mon_e.d)) begin
               errors++;
               $display("FAIL write: en=%b%b addr=%0d h=%0d d=%0d, expected en=11 addr=%0d h=%0d d=%0d",
                        wr_en_h, wr_en_d, wr_addr, wr_data_h, wr_data_d, mon_e.addr, mon_e.h, mon_e.d);
            end
         end
      end
   end

   function automatic void model_reset();
      for (int i = 0; i < VS; i++) begin
         sum_h[i] = 0;
         sum_d[i] = 0;
      end
      cnt_h = 0;
      cnt_d = 0;
      exp_err = 1'b0;
   endfunction

   function automatic void push_expected();
      for (int a = 0; a < VS; a++)
         exp_q.push_back('{a, (sum_h[a] + NS/2) / NS, (sum_d[a] + NS/2) / NS});
   endfunction

   function automatic void fill_const(input int v);
      for (int i = 0; i < VS; i++) vbuf[i] = v;
   endfunction

   function automatic void fill_rand();
      for (int i = 0; i < VS; i++) vbuf[i] = int'($urandom_range(0, 15));
   endfunction

   // Sends vbuf as one vector; gap = percent chance of an idle cycle before each element
   task automatic send_vec(input bit lbl, input int gap, input int last_pos);
      int w;
      if ((lbl ? cnt_d : cnt_h) >= NS) exp_err = 1'b1;
      else begin
         for (int i = 0; i < VS; i++) begin
            if (lbl) sum_d[i] += vbuf[i];
            else     sum_h[i] += vbuf[i];
         end
         if (lbl) cnt_d++;
         else     cnt_h++;
      end
      if (last_pos != VS - 1) exp_err = 1'b1;
      for (int i = 0; i < VS; i++) begin
         while (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
            s_valid = 1'b0;
            s_label = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         s_valid = 1'b1;
         s_data  = 4'(vbuf[i]);
         s_label = (i == 0) ? lbl : 1'($urandom_range(0, 1));
         s_last  = (i == last_pos);
         w = 0;
         while (!s_ready && w < 1000) begin
            @(posedge clk); #1;
            w++;
         end
         if (!s_ready) begin
            check("ready_timeout", 0, 1);
            s_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic end_session(input string name);
      int n;
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_done"}, int'(done), 1);
      @(negedge clk); #1;
      check({name, "_writes_left"}, exp_q.size(), 0);
      exp_q.delete();
      check({name, "_err"}, int'(err), int'(exp_err));
      start = 1'b0;
      @(posedge clk); #1;
      check({name, "_idle"}, int'({done, busy}), 0);
   endtask

   task automatic run_basic(input int gap);
      model_reset();
      start = 1'b1;
      fill_const(5);
      for (int k = 0; k < NS; k++) send_vec(1'b0, gap, VS - 1);
      fill_const(10);
      for (int k = 0; k < NS; k++) send_vec(1'b1, gap, VS - 1);
      push_expected();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int h3a[NS], d3a[NS], h3b[NS], d3b[NS];
      h3a = '{0, 0, 1, 1};
      d3a = '{15, 15, 15, 15};
      h3b = '{0, 0, 0, 1};
      d3b = '{7, 8, 8, 8};

      // 1: reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_outputs", int'({s_ready, wr_en_h, wr_en_d, busy, done, err, wr_addr, wr_data_h, wr_data_d}), 0);
      repeat (2) @(posedge clk);
      #1 check("idle_outputs", int'({s_ready, wr_en_h, wr_en_d, busy, done, err, wr_addr, wr_data_h, wr_data_d}), 0);

      // 2: constant vectors, no stalls, exact latency
      n = 0;
      fork
         run_basic(0);
         begin
            do begin
               @(posedge clk); #1;
               n++;
            end while (!done && n < 400);
         end
      join
      check("latency", n, 1 + VS + 2 * NS * VS + VS);
      end_session("basic");

      // 3: rounding and extremes at address 0
      model_reset();
      start = 1'b1;
      for (int k = 0; k < NS; k++) begin
         fill_rand(); vbuf[0] = h3a[k]; send_vec(1'b0, 10, VS - 1);
         fill_rand(); vbuf[0] = d3a[k]; send_vec(1'b1, 10, VS - 1);
      end
      push_expected();
      end_session("round_a");
      model_reset();
      start = 1'b1;
      for (int k = 0; k < NS; k++) begin
         fill_rand(); vbuf[0] = d3b[k]; send_vec(1'b1, 10, VS - 1);
      end
      for (int k = 0; k < NS; k++) begin
         fill_rand(); vbuf[0] = h3b[k]; send_vec(1'b0, 10, VS - 1);
      end
      push_expected();
      end_session("round_b");

      // 4: interleaved labels with random gaps
      for (int r = 0; r < 2; r++) begin
         model_reset();
         start = 1'b1;
         for (int k = 0; k < 2 * NS; k++) begin
            fill_rand();
            send_vec(1'(k % 2), 30, VS - 1);
         end
         push_expected();
         end_session("interleave");
      end

      // 5a: extra h vector while d still filling
      model_reset();
      start = 1'b1;
      for (int k = 0; k < NS; k++) begin fill_rand(); send_vec(1'b0, 0, VS - 1); end
      fill_rand(); send_vec(1'b1, 0, VS - 1);
      fill_const(15); send_vec(1'b0, 5, VS - 1);
      for (int k = 1; k < NS; k++) begin fill_rand(); send_vec(1'b1, 0, VS - 1); end
      push_expected();
      end_session("drop");

      // 5b: misplaced s_last; indexing must not resync
      model_reset();
      start = 1'b1;
      for (int k = 0; k < 2 * NS; k++) begin
         fill_rand();
         send_vec(1'(k / NS), 0, (k == 2) ? 7 : VS - 1);
      end
      push_expected();
      end_session("last_err");

      // 6: reset mid-WRITE, then a clean session
      run_basic(0);
      n = 0;
      while (!(wr_en_h && wr_addr == 4'd6) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach_addr6", int'(wr_en_h && wr_addr == 4'd6), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_outputs", int'({wr_en_h, wr_en_d, busy, done, s_ready}), 0);
      exp_q.delete();
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      check("abort_no_write", int'({wr_en_h, wr_en_d, busy}), 0);
      run_basic(0);
      end_session("after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
